// File: rtl/nec_ir_tx.sv
`default_nettype none
// ============================================================================
// Module      : nec_ir_tx
// Description : NEC infrared transmitter. Sends a full frame (address and
//               command bytes) or a repeat code, and drives both the
//               unmodulated envelope and the carrier-modulated LED output.
//               Every request occupies exactly 192 NEC units.
// Revision    : 1.0 - initial release
// ============================================================================
module nec_ir_tx #(
  parameter int UNIT_CYCLES  = 28125,  // clocks per NEC unit, must be >= 2
  parameter int CARRIER_HALF = 658     // clocks per carrier half-period
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       start,
  input  logic       repeat_req,
  input  logic [7:0] address,
  input  logic [7:0] command,
  output logic       ir_env,
  output logic       ir_out,
  output logic       busy,
  output logic       done
);

  localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
  // done is registered, so it is raised one cycle before the final GAP cycle ends
  localparam logic [UW-1:0] UNIT_PRE  = UW'(UNIT_CYCLES - 2);
  localparam logic [CW-1:0] CAR_LAST  = CW'(CARRIER_HALF - 1);
  localparam logic [7:0]    LAST_UNIT = 8'd191;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LEAD_MARK  = 3'd1,
    LEAD_SPACE = 3'd2,
    BIT_MARK   = 3'd3,
    BIT_SPACE  = 3'd4,
    STOP_MARK  = 3'd5,
    GAP        = 3'd6
  } state_t;

  state_t        state;
  logic [UW-1:0] unit_cnt;     // clock position inside the current unit
  logic [7:0]    frame_units;  // completed units since the lead mark began
  logic [4:0]    seg_cnt;      // units left in the current mark/space
  logic [4:0]    bit_idx;
  logic [CW-1:0] car_cnt;
  logic          car_lvl;
  logic [31:0]   word;
  logic          is_repeat;

  logic unit_end;
  logic seg_end;
  logic car_wrap;
  logic car_next;
  logic cur_bit;

  assign unit_end = (unit_cnt == UNIT_LAST);
  assign seg_end  = unit_end && (seg_cnt == 5'd1);
  assign car_wrap = (car_cnt == CAR_LAST);
  assign car_next = car_wrap ? ~car_lvl : car_lvl;
  assign cur_bit  = word[bit_idx];

  // Frame sequencer: unit timebase, segment transitions, carrier and outputs
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state       <= IDLE;
      ir_env      <= 1'b0;
      ir_out      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      unit_cnt    <= '0;
      frame_units <= '0;
      seg_cnt     <= '0;
      bit_idx     <= '0;
      car_cnt     <= '0;
      car_lvl     <= 1'b0;
      word        <= '0;
      is_repeat   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        unit_cnt    <= '0;
        frame_units <= '0;
        bit_idx     <= '0;
        if (start || repeat_req) begin
          // start wins when both are requested together
          if (start) word <= {~command, command, ~address, address};
          is_repeat <= ~start;
          state     <= LEAD_MARK;
          seg_cnt   <= 5'd16;
          ir_env    <= 1'b1;
          ir_out    <= 1'b1;
          busy      <= 1'b1;
          car_cnt   <= '0;
          car_lvl   <= 1'b1;
        end
      end else begin
        // All boundaries derive from one unit counter, so no drift accumulates
        if (unit_end) begin
          unit_cnt    <= '0;
          frame_units <= frame_units + 8'd1;
          seg_cnt     <= seg_cnt - 5'd1;
        end else begin
          unit_cnt <= unit_cnt + UW'(1);
        end

        // Carrier runs continuously; it is restarted at each mark entry
        car_cnt <= car_wrap ? '0 : car_cnt + CW'(1);
        car_lvl <= car_next;
        ir_out  <= ir_env & car_next;

        if (seg_end) begin
          case (state)
            LEAD_MARK: begin
              state   <= LEAD_SPACE;
              seg_cnt <= is_repeat ? 5'd4 : 5'd8;
              ir_env  <= 1'b0;
              ir_out  <= 1'b0;
            end
            LEAD_SPACE: begin
              state   <= is_repeat ? STOP_MARK : BIT_MARK;
              seg_cnt <= 5'd1;
              ir_env  <= 1'b1;
              ir_out  <= 1'b1;
              car_cnt <= '0;
              car_lvl <= 1'b1;
            end
            BIT_MARK: begin
              state   <= BIT_SPACE;
              seg_cnt <= cur_bit ? 5'd3 : 5'd1;
              ir_env  <= 1'b0;
              ir_out  <= 1'b0;
            end
            BIT_SPACE: begin
              seg_cnt <= 5'd1;
              ir_env  <= 1'b1;
              ir_out  <= 1'b1;
              car_cnt <= '0;
              car_lvl <= 1'b1;
              if (bit_idx == 5'd31) begin
                state <= STOP_MARK;
              end else begin
                state   <= BIT_MARK;
                bit_idx <= bit_idx + 5'd1;
              end
            end
            STOP_MARK: begin
              state  <= GAP;
              ir_env <= 1'b0;
              ir_out <= 1'b0;
            end
            default: begin
            end
          endcase
        end

        // GAP is terminated by the frame-unit count, not by a segment length
        if (state == GAP && frame_units == LAST_UNIT) begin
          if (unit_cnt == UNIT_PRE) done <= 1'b1;
          if (unit_end) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/nec_ir_tx.md
# nec_ir_tx

- Transmits one NEC infrared frame (8-bit address, 8-bit command) or an NEC repeat code on request.
- Produces the unmodulated envelope and a carrier-modulated LED drive.
- Used as the remote-control source in loopback and self-test: its frames feed the team's NEC receiver, whose command byte drives the mode and drive FSMs (for example 0x0F, 0x13, 0x10, 0x05, 0x08).

## Interface

- UNIT_CYCLES, 28125: clock cycles per NEC unit (562.5 µs at 50 MHz).
- CARRIER_HALF, 658: clock cycles per carrier half-period (about 38 kHz at 50 MHz).
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  request a full frame; sampled only in IDLE.
- repeat_req  in  1  request a repeat code; sampled only in IDLE; start takes priority.
- address  in  8  NEC address; latched when start is accepted.
- command  in  8  NEC command; latched when start is accepted.
- ir_env  out  1  envelope: 1 during mark, 0 during space or idle.
- ir_out  out  1  ir_env AND carrier; drives the IR LED.
- busy  out  1  high from the first envelope cycle through the done cycle.
- done  out  1  one-cycle pulse on the last cycle of the frame period.

## Operation

- Frame word W = {~command, command, ~address, address}. It is sent LSB first (W[0] first), so the address goes out first.
- Every duration is counted in units of UNIT_CYCLES clocks.
- States and durations:
  - IDLE: waiting for a request.
  - LEAD_MARK: 16 units, envelope high.
  - LEAD_SPACE: 8 units for a full frame, 4 units for a repeat.
  - BIT_MARK: 1 unit.
  - BIT_SPACE: 1 unit for bit 0, 3 units for bit 1.
  - STOP_MARK: 1 unit.
  - GAP: envelope low.
- Full frame path: IDLE → LEAD_MARK → LEAD_SPACE(8) → 32 × (BIT_MARK → BIT_SPACE) → STOP_MARK → GAP → IDLE.
- Repeat path: IDLE → LEAD_MARK → LEAD_SPACE(4) → STOP_MARK → GAP → IDLE.
- A frame-unit counter (8 bits, 0..191) runs from the start of LEAD_MARK. GAP ends when the counter reaches 192 units, so every request, full or repeat, occupies exactly 192 units (108 ms).
- A full frame always contains 16 one-bits, so it is 121 units of signalling plus 71 units of GAP.
- A repeat code is 21 units of signalling plus 171 units of GAP.
- Carrier:
  - The phase counter restarts at the first cycle of every mark, with the carrier high.
  - The carrier toggles every CARRIER_HALF cycles while ir_env = 1.
  - ir_out is 0 whenever ir_env = 0.
- start and repeat_req arriving outside IDLE are ignored; they are not queued.
- address and command may change freely after acceptance.
- Width rules:
  - Unit cycle counter: $clog2(UNIT_CYCLES) bits.
  - Carrier counter: $clog2(CARRIER_HALF) bits.
  - Bit index: 5 bits, 0..31. The transition out of bit 31's space goes to STOP_MARK, not back to bit 0.

## Timing

- Reset, while reset_n = 0 at a clock edge:
  - State goes to IDLE.
  - ir_env = 0, ir_out = 0, busy = 0, done = 0.
  - All counters clear.
  - The latched word clears to 0.
- A reset asserted mid-frame aborts the frame. Outputs are 0 in the cycle after the reset edge, and no done pulse is issued.
- Request accepted at edge N (IDLE with start = 1 or repeat_req = 1):
  - ir_env = 1, ir_out = 1 and busy = 1 from cycle N+1.
  - The lead mark lasts exactly 16·UNIT_CYCLES cycles.
- done is high for one cycle: cycle N + 192·UNIT_CYCLES, which is the last GAP cycle.
- In the cycle after done, busy = 0 and the state is IDLE.
- A new request can be accepted at that IDLE edge, giving back-to-back frames with no extra idle cycle.
- Each mark or space boundary moves ir_env at exactly an integer multiple of UNIT_CYCLES after cycle N+1. There is no drift accumulated across bits.
- Simultaneous start and repeat_req in IDLE send a full frame.

## Test plan

Run with UNIT_CYCLES = 4 and CARRIER_HALF = 1; the frame period is then 768 cycles.

- **Reset values:** hold reset_n = 0 for 3 cycles → all outputs 0. After release with no request → outputs stay 0.
- **Full frame:** address = 0x00, command = 0x0F, start pulse at edge N →
  - ir_env high from cycles N+1 to N+64, then low for 32 cycles.
  - Bits follow W = 0xF00FFF00, LSB first: 8 zero-bits (4 high / 4 low each), 8 one-bits (4 high / 12 low), and so on.
  - Stop mark of 4 cycles ends at N+484.
  - done at N+768; busy falls at N+769.
- **Repeat code:** repeat_req at edge N →
  - 64 cycles mark, 16 cycles space, 4 cycles mark.
  - Low until done at N+768.
- **Arbitration:**
  - start re-pulsed mid-frame → ignored; the frame duration is unchanged.
  - start and repeat_req together in IDLE → full-frame lead space of 32 cycles.
- **Reset mid-bit:** reset_n = 0 during bit 10 → the next cycle has all outputs 0 and no done pulse. A following start produces a complete, correct frame.
- **Carrier:** during any mark, ir_out = 1,0,1,0… starting at 1 on the first mark cycle. During spaces and GAP, ir_out stays 0.
